// File: rtl/pipeline_exec_controller.sv
// pipeline_exec_controller
//   Host-driven sequencer for the MIPS pipeline. Accepts command bytes from
//   the UART receiver, loads a program word-by-word into instruction memory,
//   and gates pipeline advance for continuous run or single-step.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_cmd_valid/i_cmd : host byte stream; o_cmd_ready accepts a byte
//   i_halt_retired    : HALT_WORD reached writeback (RUN/STEP only)
//   o_imem_we/addr/data : instruction memory write port
//   o_pipe_enable     : pipeline advance enable (PC write + stage regs)
//   o_pipe_rst        : one-cycle pipeline clear pulse at load start
//   o_state           : FSM state encoding
//   o_load_overflow   : sticky, memory filled without HALT
//   o_cycle_count     : enabled-cycle count
//
// Optional feature macro: CYCLE_COUNT_EN (enables o_cycle_count counter;
// otherwise o_cycle_count is tied to 0).

module pipeline_exec_controller #(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  input  logic [7:0]        i_cmd,
  output logic              o_cmd_ready,
  input  logic              i_halt_retired,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_data,
  output logic              o_pipe_enable,
  output logic              o_pipe_rst,
  output logic [2:0]        o_state,
  output logic              o_load_overflow,
  output logic [31:0]       o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              pipe_rst_q, pipe_rst_d;
  logic              ovf_q, ovf_d;
  logic              finish_q, finish_d;
  logic              cmd_ready_q, cmd_ready_d;

  logic              xfer;
  logic [31:0]       word_next;

  assign xfer      = i_cmd_valid & cmd_ready_q;
  assign word_next = {word_q[23:0], i_cmd};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_cnt_d = addr_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    pipe_rst_d = 1'b0;
    ovf_d      = ovf_q;
    finish_d   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (xfer && i_cmd == CMD_LOAD) begin
          state_d    = S_LOAD;
          pipe_rst_d = 1'b1;
          addr_cnt_d = '0;
          byte_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end

      S_READY: begin
        if (xfer) begin
          if (i_cmd == CMD_LOAD) begin
            state_d    = S_LOAD;
            pipe_rst_d = 1'b1;
            addr_cnt_d = '0;
            byte_cnt_d = '0;
            ovf_d      = 1'b0;
          end else if (i_cmd == CMD_RUN) begin
            state_d = S_RUN;
          end else if (i_cmd == CMD_STEP) begin
            state_d = S_STEP;
          end
        end
      end

      S_LOAD: begin
        // The terminating word's write strobe is issued one cycle after the
        // 4th byte, so LOAD is held for that cycle (finish_q) to keep the
        // strobe inside LOAD; bytes arriving in that cycle are dropped.
        if (finish_q) begin
          state_d = S_READY;
        end else if (xfer) begin
          word_d     = word_next;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = addr_cnt_q;
            data_d = word_next;
            if (word_next == HALT_WORD) begin
              finish_d = 1'b1;
            end else if (addr_cnt_q == '1) begin
              finish_d = 1'b1;
              ovf_d    = 1'b1;
            end
            // Counter saturates at the last address rather than wrapping.
            if (addr_cnt_q != '1) begin
              addr_cnt_d = addr_cnt_q + 1'b1;
            end
          end
        end
      end

      S_RUN: begin
        if (i_halt_retired) begin
          state_d = S_DONE;
        end
      end

      S_STEP: begin
        state_d = i_halt_retired ? S_DONE : S_READY;
      end

      default: state_d = S_IDLE;
    endcase

    // Ready is registered from the next state so it is low out of reset.
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD) ||
                  (state_d == S_READY) || (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      addr_cnt_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      pipe_rst_q  <= 1'b0;
      ovf_q       <= 1'b0;
      finish_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      addr_cnt_q  <= addr_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pipe_rst_q  <= pipe_rst_d;
      ovf_q       <= ovf_d;
      finish_q    <= finish_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign o_cmd_ready     = cmd_ready_q;
  assign o_imem_we       = we_q;
  assign o_imem_addr     = addr_q;
  assign o_imem_data     = data_q;
  assign o_pipe_enable   = (state_q == S_RUN) || (state_q == S_STEP);
  assign o_pipe_rst      = pipe_rst_q;
  assign o_state         = state_q;
  assign o_load_overflow = ovf_q;

`ifdef CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (pipe_rst_q) begin
      cyc_d = '0;
    end else if (o_pipe_enable) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign o_cycle_count = cyc_q;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Testbench for pipeline_exec_controller: directed stimulus with a write
// scoreboard (expected imem writes queued at stimulus time, popped on strobe).
module tb_pipeline_exec_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic [7:0]  i_cmd = 8'h00;
  logic        o_cmd_ready;
  logic        i_halt_retired = 1'b0;
  logic        o_imem_we;
  logic [5:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  logic        o_pipe_enable;
  logic        o_pipe_rst;
  logic [2:0]  o_state;
  logic        o_load_overflow;
  logic [31:0] o_cycle_count;

  pipeline_exec_controller #(.ADDR_W(6), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready),
    .i_halt_retired(i_halt_retired),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_pipe_enable(o_pipe_enable), .o_pipe_rst(o_pipe_rst), .o_state(o_state),
    .o_load_overflow(o_load_overflow), .o_cycle_count(o_cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
  wr_t wq[$];

  int errors = 0;
  int checks = 0;
  int writes_seen = 0;
  int en_cnt = 0;
  int prst_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    wr_t w;
    if (o_pipe_enable) en_cnt++;
    if (o_pipe_rst) prst_cnt++;
    if (o_imem_we) begin
      writes_seen++;
      chk("we_in_load", {29'd0, o_state}, 32'd1);
      if (wq.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", {26'd0, o_imem_addr}, {26'd0, w.a});
        chk("wr_data", o_imem_data, w.d);
      end
    end
    if (o_pipe_enable) chk("en_state", {31'd0, (o_state == 3'd3 || o_state == 3'd4)}, 32'd1);
    if (o_state == 3'd3) chk("ready_in_run", {31'd0, o_cmd_ready}, 32'd0);
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_cmd = b;
    i_cmd_valid = 1'b1;
    @(negedge clk);
    while (!o_cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wq.push_back(w);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    idle_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {29'd0, o_state}, 32'd0);
    chk("rst_ready", {31'd0, o_cmd_ready}, 32'd0);
    chk("rst_we", {31'd0, o_imem_we}, 32'd0);
    chk("rst_en", {31'd0, o_pipe_enable}, 32'd0);
    chk("rst_prst", {31'd0, o_pipe_rst}, 32'd0);
    chk("rst_ovf", {31'd0, o_load_overflow}, 32'd0);
    chk("rst_cyc", o_cycle_count, 32'd0);
    idle_cycles(1);

    // R and S ignored in IDLE
    send_byte(8'h52);
    send_byte(8'h53);
    idle_cycles(2);
    chk("idle_ignore_state", {29'd0, o_state}, 32'd0);
    chk("idle_ignore_en", en_cnt, 32'd0);

    // Load a two-word program
    prst_cnt = 0;
    send_byte(8'h4C);
    push_wr(6'd0, 32'h2008_0005);
    push_wr(6'd1, 32'hFFFF_FFFF);
    send_word(32'h2008_0005);
    send_word(32'hFFFF_FFFF);
    idle_cycles(3);
    chk("load_state", {29'd0, o_state}, 32'd2);
    chk("load_ovf", {31'd0, o_load_overflow}, 32'd0);
    chk("load_prst", prst_cnt, 32'd1);
    chk("load_writes", writes_seen, 32'd2);
    chk("load_q_empty", wq.size(), 32'd0);

    // Unknown byte and stray halt in READY
    send_byte(8'h41);
    i_halt_retired = 1'b1;
    idle_cycles(1);
    i_halt_retired = 1'b0;
    idle_cycles(2);
    chk("ready_ignore_state", {29'd0, o_state}, 32'd2);
    chk("ready_ignore_en", en_cnt, 32'd0);

    // Run with 'S' held on the link; halt retires in the 10th RUN cycle
    en_cnt = 0;
    send_byte(8'h52);
    i_cmd = 8'h53;
    i_cmd_valid = 1'b1;
    idle_cycles(9);
    i_halt_retired = 1'b1;
    idle_cycles(1);
    i_halt_retired = 1'b0;
    idle_cycles(2);
    i_cmd_valid = 1'b0;
    idle_cycles(2);
    chk("run_en_cycles", en_cnt, 32'd10);
    chk("run_done_state", {29'd0, o_state}, 32'd5);
`ifdef CYCLE_COUNT_EN
    chk("run_cycle_count", o_cycle_count, 32'd10);
`else
    chk("run_cycle_count", o_cycle_count, 32'd0);
`endif
    send_byte(8'h52);
    idle_cycles(3);
    chk("done_ignore_state", {29'd0, o_state}, 32'd5);
    chk("done_ignore_en", en_cnt, 32'd10);
`ifdef CYCLE_COUNT_EN
    chk("done_cycle_hold", o_cycle_count, 32'd10);
`endif

    // Step: reload from DONE, then three single steps
    send_byte(8'h4C);
    push_wr(6'd0, 32'h1234_5678);
    push_wr(6'd1, 32'hFFFF_FFFF);
    send_word(32'h1234_5678);
    send_word(32'hFFFF_FFFF);
    idle_cycles(3);
    chk("step_load_state", {29'd0, o_state}, 32'd2);
    chk("step_cyc_cleared", o_cycle_count, 32'd0);
    for (int k = 0; k < 3; k++) begin
      en_cnt = 0;
      send_byte(8'h53);
      if (k == 2) i_halt_retired = 1'b1;
      idle_cycles(1);
      i_halt_retired = 1'b0;
      idle_cycles(3);
      chk("step_en_pulse", en_cnt, 32'd1);
      chk("step_state", {29'd0, o_state}, (k == 2) ? 32'd5 : 32'd2);
    end
`ifdef CYCLE_COUNT_EN
    chk("step_cycle_count", o_cycle_count, 32'd3);
`endif

    // Overflow: 64 non-HALT words
    writes_seen = 0;
    send_byte(8'h4C);
    for (int i = 0; i < 64; i++) begin
      push_wr(6'(i), 32'h0000_0000);
      send_word(32'h0000_0000);
    end
    idle_cycles(3);
    chk("ovf_writes", writes_seen, 32'd64);
    chk("ovf_q_empty", wq.size(), 32'd0);
    chk("ovf_flag", {31'd0, o_load_overflow}, 32'd1);
    chk("ovf_state", {29'd0, o_state}, 32'd2);

    // Reset mid-load after two bytes of a word
    writes_seen = 0;
    send_byte(8'h4C);
    send_byte(8'hAB);
    send_byte(8'hCD);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_state", {29'd0, o_state}, 32'd0);
    chk("mrst_we", {31'd0, o_imem_we}, 32'd0);
    chk("mrst_en", {31'd0, o_pipe_enable}, 32'd0);
    chk("mrst_ready", {31'd0, o_cmd_ready}, 32'd0);
    chk("mrst_ovf", {31'd0, o_load_overflow}, 32'd0);
    chk("mrst_prst", {31'd0, o_pipe_rst}, 32'd0);
    idle_cycles(1);
    en_cnt = 0;
    send_byte(8'h52);
    idle_cycles(4);
    chk("mrst_run_ignored", {29'd0, o_state}, 32'd0);
    chk("mrst_no_en", en_cnt, 32'd0);
    chk("mrst_no_write", writes_seen, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_exec_controller.md
Name: pipeline_exec_controller

Overview:
- Sequences the MIPS pipeline from a host byte stream.
- Accepts commands, then loads a program word-by-word into the instruction memory write port.
- Gates pipeline advance through a single enable that feeds PC write and all stage registers.
- Supports continuous run until HALT retires, and single-step.
- Sits between the host byte link (UART receiver) and the Instruction_Fetch/pipeline top.

Parameters:
- ADDR_W, 6, instruction memory word-address width; depth is 2^ADDR_W words.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that terminates load and run.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_cmd_valid  in  1  host byte valid
- i_cmd  in  8  host byte
- o_cmd_ready  out  1  controller accepts a byte this cycle
- i_halt_retired  in  1  pulse from WB stage: HALT_WORD reached writeback
- o_imem_we  out  1  instruction memory write strobe
- o_imem_addr  out  ADDR_W  instruction memory write address
- o_imem_data  out  32  instruction memory write data
- o_pipe_enable  out  1  pipeline advance enable; ANDed into PC write and stage registers
- o_pipe_rst  out  1  one-cycle pipeline clear pulse; PC returns to 0
- o_state  out  3  current FSM state encoding
- o_load_overflow  out  1  sticky: memory filled without HALT
- o_cycle_count  out  32  enabled-cycle count (see Optional Feature)

Behaviour:
- Reset, synchronous, active-high, sampled on the clk rising edge:
  - state=IDLE (0).
  - All outputs 0, including o_cmd_ready.
  - Address counter and byte counter 0.
- Byte transfer occurs on the cycle where i_cmd_valid & o_cmd_ready are both high.
- o_cmd_ready is high in IDLE, LOAD, READY and DONE; low in RUN and STEP.
- Command bytes:
  - 'L' = 0x4C
  - 'R' = 0x52
  - 'S' = 0x53
  - Any other byte in IDLE/READY/DONE is consumed and ignored.
- State encodings: IDLE=0, LOAD=1, READY=2, RUN=3, STEP=4, DONE=5.
- IDLE:
  - 'L' -> LOAD. o_pipe_rst=1 for exactly that transition cycle; addr counter=0; byte counter=0; o_load_overflow cleared.
  - 'R' and 'S' are ignored.
- LOAD:
  - Each transferred byte shifts into the word register, MSB first.
  - On the 4th byte, o_imem_we=1 for one cycle, with o_imem_data=assembled word and o_imem_addr=current counter. The counter then increments.
  - Write latency: 4th byte accepted at edge N -> o_imem_we high during cycle N+1.
  - Word == HALT_WORD: the word is written, then -> READY.
  - Counter at 2^ADDR_W-1 and the word is not HALT: the word is written, o_load_overflow=1, then -> READY. The counter does not wrap into address 0.
- READY:
  - 'R' -> RUN.
  - 'S' -> STEP.
  - 'L' -> LOAD, with the same actions as from IDLE.
- RUN:
  - o_pipe_enable=1 every cycle.
  - i_halt_retired=1 -> DONE. o_pipe_enable drops in the next cycle.
- STEP:
  - o_pipe_enable=1 for exactly one cycle, then -> READY.
  - If i_halt_retired=1 during that cycle -> DONE instead.
- DONE:
  - o_pipe_enable=0; the pipeline is frozen and its state is observable.
  - 'L' -> LOAD.
  - 'R' and 'S' are ignored.
- i_halt_retired outside RUN/STEP is ignored.
- Reset asserted mid-LOAD or mid-RUN aborts immediately to IDLE. Memory contents are untouched (no write is issued).
- o_imem_we is never high outside LOAD.
- o_pipe_enable is never high outside RUN/STEP.

Optional Feature:
- Macro: CYCLE_COUNT_EN.
- Defined:
  - o_cycle_count increments by 1 on every cycle with o_pipe_enable=1.
  - Cleared to 0 on rst and on o_pipe_rst.
  - Wraps modulo 2^32.
  - Holds its value in DONE.
- Undefined: o_cycle_count is tied to 0 and no counter register exists.

Test Plan:
- Load: send 4C, then 20 08 00 05, then FF FF FF FF.
  - Expect o_pipe_rst pulse.
  - Expect write addr0=0x20080005, then write addr1=0xFFFFFFFF.
  - Expect state=READY and o_load_overflow=0.
- Run: send 52, hold i_cmd_valid=1 with byte 53 during RUN, and pulse i_halt_retired 10 cycles later.
  - Expect o_pipe_enable high for exactly 10 cycles and o_cmd_ready=0 throughout RUN.
  - Expect state=DONE.
  - With CYCLE_COUNT_EN defined, expect o_cycle_count=10.
- Step: load a program, then send 53 three times with gaps.
  - Expect three isolated 1-cycle o_pipe_enable pulses and state=READY after each.
  - Pulse i_halt_retired during the 3rd step -> expect DONE.
- Overflow: load 64 non-HALT words (0x00000000).
  - Expect 64 writes at addr 0..63 with no wrap.
  - Expect o_load_overflow=1 and state READY.
- Reset mid-load: assert rst after 2 bytes of a word.
  - Expect IDLE, all outputs 0, and no o_imem_we.
  - A following 52 is ignored.
- Ignored commands: send 52 and 53 in IDLE, then 41 in READY.
  - Expect no state change and o_pipe_enable stays 0.
